trigger_scaler_x8: RTL and testbench

- Downstream consumer of the 8-channel trigger chain. Takes the per-channel 8×5-bit AGC/biquad outputs (dat_o of the chain, 40 bits/channel) and counts per-channel threshold-crossing clocks over a programmable gate.
- At the end of each gate it latches the 8 counts and streams them out as 8 AXI4-Stream-style beats for the rate monitor and threshold servo.

---
 rtl/trigger_scaler_x8_if.sv | 11 +
 rtl/trigger_scaler_x8.sv | 146 ++++++++++++++
 tb/tb_trigger_scaler_x8.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_scaler_x8_if.sv
// AXI4-Stream-style readout channel carrying per-channel hit counts from the
// trigger scaler to the rate monitor and threshold servo.
interface trigger_scaler_x8_if;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/trigger_scaler_x8.sv
// Counts per-channel threshold-crossing clocks over a programmable gate and
// streams the eight latched counts out as one 8-beat packet per gate.
module trigger_scaler_x8 #(
  parameter int CNT_BITS    = 16,
  parameter int PERIOD_BITS = 24
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [7:0][39:0]       dat_i,
  input  logic [4:0]             thresh_i,
  input  logic [PERIOD_BITS-1:0] period_i,
  input  logic                   enable_i,
  trigger_scaler_x8_if.master    axis,
  output logic                   overrun_o
);

  typedef enum logic {IDLE, SEND} state_e;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [7:0][39:0]         dat_q;
  logic                     en_q;
  logic [7:0][CNT_BITS-1:0] cnt_q, cnt_d, cntInc, cntSh_q;
  logic [7:0]               sat_q, sat_d, satInc, satSh_q, hit;
  logic [PERIOD_BITS-1:0]   gcnt_q, gcnt_d, gateLen_q, gateLen_d, effLen;
  logic                     gateEnd;
  state_e                   state_q;
  logic [2:0]               ch_q, chNext;
  logic [31:0]              tdata_q;
  logic                     tvalid_q, tlast_q, overrun_q;

  // -16 maps to 16: the 5-bit negate wraps to 5'b10000, read back as unsigned.
  function automatic logic [4:0] magOf(input logic [4:0] x);
    return x[4] ? (~x + 5'd1) : x;
  endfunction

  function automatic logic [31:0] beatOf(input logic [2:0] ch, input logic s,
                                         input logic [CNT_BITS-1:0] n);
    return {ch, s, 12'b0, 16'(n)};
  endfunction

  always_comb begin
    hit = '0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) begin
        if (magOf(dat_q[c][5*k +: 5]) >= thresh_i) hit[c] = 1'b1;
      end
    end
  end

  // The gate length is taken from period_i on the first counted cycle of a gate,
  // so a one-cycle gate can end on the same cycle it starts.
  always_comb begin
    cntInc = cnt_q;
    satInc = sat_q;
    for (int c = 0; c < 8; c++) begin
      if (hit[c]) begin
        if (cnt_q[c] == CNT_MAX) satInc[c] = 1'b1;
        else                     cntInc[c] = cnt_q[c] + CNT_BITS'(1);
      end
    end

    effLen  = (gcnt_q == '0) ? ((period_i == '0) ? PERIOD_BITS'(1) : period_i) : gateLen_q;
    gateEnd = en_q && (gcnt_q == effLen - PERIOD_BITS'(1));

    cnt_d     = cnt_q;
    sat_d     = sat_q;
    gcnt_d    = gcnt_q;
    gateLen_d = gateLen_q;
    if (!en_q || gateEnd) begin
      cnt_d  = '0;
      sat_d  = '0;
      gcnt_d = '0;
      if (en_q) gateLen_d = effLen;
    end else begin
      cnt_d     = cntInc;
      sat_d     = satInc;
      gcnt_d    = gcnt_q + PERIOD_BITS'(1);
      gateLen_d = effLen;
    end
  end

  assign chNext = ch_q + 3'd1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dat_q     <= '0;
      en_q      <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= '0;
      gcnt_q    <= '0;
      gateLen_q <= '0;
      cntSh_q   <= '0;
      satSh_q   <= '0;
      state_q   <= IDLE;
      ch_q      <= 3'd0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dat_q     <= dat_i;
      en_q      <= enable_i;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      gcnt_q    <= gcnt_d;
      gateLen_q <= gateLen_d;
      overrun_q <= gateEnd && (state_q == SEND);

      case (state_q)
        IDLE: begin
          if (gateEnd) begin
            cntSh_q  <= cntInc;
            satSh_q  <= satInc;
            ch_q     <= 3'd0;
            tdata_q  <= beatOf(3'd0, satInc[0], cntInc[0]);
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (axis.m_tready) begin
            if (ch_q == 3'd7) begin
              ch_q     <= 3'd0;
              tdata_q  <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state_q  <= IDLE;
            end else begin
              ch_q    <= chNext;
              tdata_q <= beatOf(chNext, satSh_q[chNext], cntSh_q[chNext]);
              tlast_q <= (chNext == 3'd7);
            end
          end
        end
      endcase
    end
  end

  assign axis.m_tdata  = tdata_q;
  assign axis.m_tvalid = tvalid_q;
  assign axis.m_tlast  = tlast_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_trigger_scaler_x8.sv
// Self-checking bench for trigger_scaler_x8: directed vector table, corner-case
// sequences and randomized traffic checked cycle by cycle against a gate/queue model.
module tb_trigger_scaler_x8;

  localparam int CNT_BITS    = 4;
  localparam int PERIOD_BITS = 24;
  localparam int CNT_MAX     = (1 << CNT_BITS) - 1;

  logic                   aclk     = 1'b0;
  logic                   aresetn  = 1'b0;
  logic [7:0][39:0]       dat_i    = '0;
  logic [4:0]             thresh_i = '0;
  logic [PERIOD_BITS-1:0] period_i = '0;
  logic                   enable_i = 1'b0;
  logic                   overrun_o;

  trigger_scaler_x8_if axis ();

  int vectors     = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  trigger_scaler_x8 #(.CNT_BITS(CNT_BITS), .PERIOD_BITS(PERIOD_BITS)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .dat_i     (dat_i),
    .thresh_i  (thresh_i),
    .period_i  (period_i),
    .enable_i  (enable_i),
    .axis      (axis),
    .overrun_o (overrun_o)
  );

  typedef struct {int chan; int cnt; bit sat;} beat_t;

  typedef struct {
    int         period;
    int         thresh;
    int         chan;
    int         sample;
    logic [4:0] value;
    int         expCnt;
    int         expOther;
    bit         expSat;
  } vec_t;

  // Reference model: integer hit counts per gate and a queue of the beats still owed.
  beat_t            expQ[$];
  int               mCnt[8];
  bit               mSat[8];
  int               mGcnt = 0;
  int               mLen = 1;
  bit               mEnQ = 1'b0;
  bit               mBusy = 1'b0;
  bit               mHit = 1'b0;
  bit               mOverrun = 1'b0;
  logic [7:0][39:0] mDatQ = '0;
  bit               checkOn = 1'b0;

  function automatic int sampleMag(input logic [4:0] raw);
    int v;
    v = int'(raw);
    if (v >= 16) v = v - 32;
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] expBeat(input int chan, input int cnt, input bit sat);
    return {3'(chan), sat, 12'b0, 16'(cnt)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < 8; c++) begin
        mCnt[c] = 0;
        mSat[c] = 1'b0;
      end
      expQ.delete();
      mGcnt = 0;
      mLen = 1;
      mEnQ = 1'b0;
      mDatQ = '0;
      mOverrun = 1'b0;
    end else begin
      mBusy = (expQ.size() > 0);
      mOverrun = 1'b0;
      if (mEnQ) begin
        if (mGcnt == 0) mLen = (period_i == '0) ? 1 : int'(period_i);
        for (int c = 0; c < 8; c++) begin
          mHit = 1'b0;
          for (int k = 0; k < 8; k++)
            if (sampleMag(mDatQ[c][5*k +: 5]) >= int'(thresh_i)) mHit = 1'b1;
          if (mHit) begin
            if (mCnt[c] == CNT_MAX) mSat[c] = 1'b1;
            else mCnt[c]++;
          end
        end
        mGcnt++;
        if (mGcnt == mLen) begin
          if (!mBusy) begin
            for (int c = 0; c < 8; c++) expQ.push_back('{chan: c, cnt: mCnt[c], sat: mSat[c]});
          end else begin
            mOverrun = 1'b1;
          end
          for (int c = 0; c < 8; c++) begin
            mCnt[c] = 0;
            mSat[c] = 1'b0;
          end
          mGcnt = 0;
        end
      end else begin
        for (int c = 0; c < 8; c++) begin
          mCnt[c] = 0;
          mSat[c] = 1'b0;
        end
        mGcnt = 0;
      end
      if (mBusy && axis.m_tready) void'(expQ.pop_front());
      mEnQ = enable_i;
      mDatQ = dat_i;
    end
  end

  always @(negedge aclk) begin
    if (checkOn && aresetn) begin
      checkOutput("modelValid", {31'b0, axis.m_tvalid}, {31'b0, expQ.size() > 0});
      if (expQ.size() > 0) begin
        checkOutput("modelData", axis.m_tdata, expBeat(expQ[0].chan, expQ[0].cnt, expQ[0].sat));
        checkOutput("modelLast", {31'b0, axis.m_tlast}, {31'b0, expQ[0].chan == 7});
      end
      checkOutput("modelOverrun", {31'b0, overrun_o}, {31'b0, mOverrun});
    end
  end

  task automatic applyStimulus(input vec_t v);
    dat_i = '0;
    dat_i[v.chan][5*v.sample +: 5] = v.value;
    thresh_i = 5'(v.thresh);
    period_i = PERIOD_BITS'(v.period);
    axis.m_tready = 1'b1;
    enable_i = 1'b1;
  endtask

  task automatic quiesce();
    int quiet;
    quiet = 0;
    enable_i = 1'b0;
    axis.m_tready = 1'b1;
    for (int i = 0; i < 60 && quiet < 3; i++) begin
      @(negedge aclk);
      if (axis.m_tvalid) quiet = 0;
      else quiet++;
    end
    if (quiet < 3) failNow("quiesce");
  endtask

  task automatic waitValid(input string name);
    int i;
    for (i = 0; i < 80 && !axis.m_tvalid; i++) @(negedge aclk);
    if (!axis.m_tvalid) failNow(name);
  endtask

  task automatic collectStream(input string name, output logic [7:0][31:0] beats,
                               output logic [7:0] lasts);
    int idx;
    idx = 0;
    beats = '0;
    lasts = '0;
    for (int i = 0; i < 80 && idx < 8; i++) begin
      if (axis.m_tvalid && axis.m_tready) begin
        beats[idx] = axis.m_tdata;
        lasts[idx] = axis.m_tlast;
        idx++;
      end
      @(negedge aclk);
    end
    if (idx < 8) failNow(name);
  endtask

  initial begin
    vec_t             vecs[7];
    logic [7:0][31:0] beats;
    logic [7:0]       lasts;
    int               pulses;
    int               expCnt;
    bit               expSat;

    vecs[0] = '{period: 4,  thresh: 8,  chan: 0, sample: 0, value: 5'b01000, expCnt: 4,  expOther: 0, expSat: 1'b0};
    vecs[1] = '{period: 1,  thresh: 16, chan: 1, sample: 7, value: 5'b10000, expCnt: 1,  expOther: 0, expSat: 1'b0};
    vecs[2] = '{period: 1,  thresh: 16, chan: 2, sample: 3, value: 5'b01111, expCnt: 0,  expOther: 0, expSat: 1'b0};
    vecs[3] = '{period: 1,  thresh: 0,  chan: 0, sample: 0, value: 5'b00000, expCnt: 1,  expOther: 1, expSat: 1'b0};
    vecs[4] = '{period: 20, thresh: 8,  chan: 5, sample: 2, value: 5'b10111, expCnt: 15, expOther: 0, expSat: 1'b1};
    vecs[5] = '{period: 3,  thresh: 17, chan: 6, sample: 4, value: 5'b10000, expCnt: 0,  expOther: 0, expSat: 1'b0};
    vecs[6] = '{period: 0,  thresh: 15, chan: 3, sample: 1, value: 5'b10001, expCnt: 1,  expOther: 0, expSat: 1'b0};

    axis.m_tready = 1'b0;
    repeat (3) @(negedge aclk);
    checkOutput("resetValid",   {31'b0, axis.m_tvalid}, 32'd0);
    checkOutput("resetData",    axis.m_tdata, 32'd0);
    checkOutput("resetLast",    {31'b0, axis.m_tlast}, 32'd0);
    checkOutput("resetOverrun", {31'b0, overrun_o}, 32'd0);
    aresetn = 1'b1;
    checkOn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      quiesce();
      applyStimulus(vecs[v]);
      collectStream($sformatf("vec%0dStream", v), beats, lasts);
      for (int c = 0; c < 8; c++) begin
        expCnt = (c == vecs[v].chan) ? vecs[v].expCnt : vecs[v].expOther;
        expSat = (c == vecs[v].chan) ? vecs[v].expSat : 1'b0;
        checkOutput($sformatf("vec%0dBeat%0d", v, c), beats[c], expBeat(c, expCnt, expSat));
      end
      checkOutput($sformatf("vec%0dLast", v), {24'b0, lasts}, 32'h80);
    end

    // Backpressure: beat 0 must hold while stalled and the gates that finish meanwhile are dropped.
    quiesce();
    axis.m_tready = 1'b0;
    dat_i = '0;
    dat_i[0][4:0] = 5'b01000;
    thresh_i = 5'd8;
    period_i = PERIOD_BITS'(4);
    enable_i = 1'b1;
    waitValid("bpWait");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bpValid", {31'b0, axis.m_tvalid}, 32'd1);
      checkOutput("bpData", axis.m_tdata, expBeat(0, 4, 1'b0));
      if (overrun_o) pulses++;
      @(negedge aclk);
    end
    checkOutput("bpOverrunPulses", pulses, 32'd2);
    axis.m_tready = 1'b1;
    collectStream("bpStream", beats, lasts);
    checkOutput("bpStreamCh0", beats[0], expBeat(0, 4, 1'b0));
    collectStream("bpNextStream", beats, lasts);
    checkOutput("bpNextCh0", beats[0], expBeat(0, 4, 1'b0));

    // Saturation, then a hit-free gate must report a cleared count and sat flag.
    quiesce();
    dat_i = '0;
    dat_i[0][4:0] = 5'b01000;
    thresh_i = 5'd8;
    period_i = PERIOD_BITS'(20);
    enable_i = 1'b1;
    collectStream("satStream", beats, lasts);
    checkOutput("satCh0", beats[0], expBeat(0, 15, 1'b1));
    dat_i = '0;
    collectStream("satPartialStream", beats, lasts);
    collectStream("satClearStream", beats, lasts);
    checkOutput("satClearCh0", beats[0], expBeat(0, 0, 1'b0));

    // Enable drop after three hits discards the partial gate.
    quiesce();
    dat_i = '0;
    dat_i[0][4:0] = 5'b01000;
    thresh_i = 5'd8;
    period_i = PERIOD_BITS'(8);
    enable_i = 1'b1;
    repeat (3) @(negedge aclk);
    enable_i = 1'b0;
    repeat (3) @(negedge aclk);
    enable_i = 1'b1;
    collectStream("enStream", beats, lasts);
    checkOutput("enDropCh0", beats[0], expBeat(0, 8, 1'b0));

    // Async reset while beat 3 is handshaking.
    quiesce();
    period_i = PERIOD_BITS'(4);
    enable_i = 1'b1;
    for (int i = 0; i < 80 && !(axis.m_tvalid && axis.m_tdata[31:29] == 3'd3); i++)
      @(negedge aclk);
    if (!(axis.m_tvalid && axis.m_tdata[31:29] == 3'd3)) failNow("rstBeat3Wait");
    aresetn = 1'b0;
    #1;
    checkOutput("rstAsyncValid", {31'b0, axis.m_tvalid}, 32'd0);
    checkOutput("rstAsyncLast",  {31'b0, axis.m_tlast}, 32'd0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    collectStream("rstStream", beats, lasts);
    checkOutput("rstFreshCh0", beats[0], expBeat(0, 4, 1'b0));
    checkOutput("rstFreshCh1", beats[1], expBeat(1, 0, 1'b0));

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 64 == 0) begin
        thresh_i = 5'($urandom_range(17, 12));
        period_i = PERIOD_BITS'($urandom_range(6, 0));
      end
      for (int c = 0; c < 8; c++) dat_i[c] = {8'($urandom), 32'($urandom)};
      enable_i = ($urandom_range(9, 0) != 0);
      axis.m_tready = ($urandom_range(3, 0) != 0);
      @(negedge aclk);
    end
    quiesce();

    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL globalTimeout: simulation did not complete, %0d vectors so far", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
